// File: rtl/rs_fu_scheduler_if.sv
// rs_fu_scheduler_if: issue, functional-unit and CDB signals of the reservation-station scheduler
// slave  - scheduler side: takes issue/cdb_in/fu results, drives issue_ready, fu dispatch and cdb_out
// master - environment side: decode, functional unit and CDB arbiter
interface rs_fu_scheduler_if #(parameter int DATA_W = 16, parameter int TAG_W = 3);
    logic              issue_valid, issue_ready;
    logic [15:0]       issue_inst;
    logic [TAG_W-1:0]  issue_tag, issue_qj, issue_qk;
    logic [DATA_W-1:0] issue_vj, issue_vk;
    logic              cdb_valid_in;
    logic [TAG_W-1:0]  cdb_tag_in;
    logic [DATA_W-1:0] cdb_data_in;
    logic              fu_start, fu_avail, fu_done;
    logic [15:0]       fu_inst;
    logic [TAG_W-1:0]  fu_code, fu_code_out;
    logic [DATA_W-1:0] fu_reg1, fu_reg2, fu_dout;
    logic              cdb_req, cdb_grant;
    logic [TAG_W-1:0]  cdb_tag_out;
    logic [DATA_W-1:0] cdb_data_out;
    modport slave (
        input  issue_valid, issue_inst, issue_tag, issue_qj, issue_qk, issue_vj, issue_vk,
        input  cdb_valid_in, cdb_tag_in, cdb_data_in, fu_avail, fu_done, fu_code_out, fu_dout, cdb_grant,
        output issue_ready, fu_start, fu_inst, fu_code, fu_reg1, fu_reg2, cdb_req, cdb_tag_out, cdb_data_out
    );
    modport master (
        output issue_valid, issue_inst, issue_tag, issue_qj, issue_qk, issue_vj, issue_vk,
        output cdb_valid_in, cdb_tag_in, cdb_data_in, fu_avail, fu_done, fu_code_out, fu_dout, cdb_grant,
        input  issue_ready, fu_start, fu_inst, fu_code, fu_reg1, fu_reg2, cdb_req, cdb_tag_out, cdb_data_out
    );
endinterface

// File: rtl/rs_fu_scheduler.sv
// rs_fu_scheduler: Tomasulo reservation station feeding one functional unit and the CDB
// clock, reset_n (async, active low); bus: rs_fu_scheduler_if.slave; occupancy: non-free entry count
// Optional AGE_PRIORITY_EN: dispatch the oldest READY entry instead of the lowest-index one
module rs_fu_scheduler #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    rs_fu_scheduler_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    typedef enum logic [1:0] {E_FREE, E_WAIT, E_READY, E_EXEC} ent_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BCAST} st_t;
    ent_t              ent [DEPTH];
    logic [15:0]       inst [DEPTH];
    logic [TAG_W-1:0]  tag [DEPTH], qj [DEPTH], qk [DEPTH];
    logic [DATA_W-1:0] vj [DEPTH], vk [DEPTH];
    st_t               state;
    logic [IW-1:0]     cur, sel, slot;
    logic              found, has_free, take, go, in_j, in_k;
    logic [DEPTH-1:0]  hit_j, hit_k;
    always_comb begin
        has_free  = 1'b0;
        slot      = '0;
        occupancy = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ent[i] == E_FREE) begin
                has_free = 1'b1;
                slot     = IW'(i);
            end
            occupancy = occupancy + OW'(ent[i] != E_FREE);
            hit_j[i]  = bus.cdb_valid_in && qj[i] != '0 && qj[i] == bus.cdb_tag_in;
            hit_k[i]  = bus.cdb_valid_in && qk[i] != '0 && qk[i] == bus.cdb_tag_in;
        end
    end
    // an issue waiting on the tag broadcast in the same cycle captures it directly
    assign in_j = bus.cdb_valid_in && bus.issue_qj != '0 && bus.issue_qj == bus.cdb_tag_in;
    assign in_k = bus.cdb_valid_in && bus.issue_qk != '0 && bus.issue_qk == bus.cdb_tag_in;
    assign take = bus.issue_valid && has_free;
    assign bus.issue_ready = has_free;
`ifdef AGE_PRIORITY_EN
    logic [DEPTH-1:0] age [DEPTH];
    // strict > keeps ties on the lowest index
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent[i] == E_READY && (!found || age[i] > age[sel])) begin
                found = 1'b1;
                sel   = IW'(i);
            end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        else
            for (int i = 0; i < DEPTH; i++)
                age[i] <= (take && slot == IW'(i)) ? '0 :
                          (ent[i] != E_FREE && !(&age[i])) ? age[i] + 1'b1 : age[i];
    end
`else
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (ent[i] == E_READY) begin
                found = 1'b1;
                sel   = IW'(i);
            end
    end
`endif
    // dispatch is presented combinationally so a READY entry starts in the very next cycle
    assign go           = state == S_IDLE && found && bus.fu_avail;
    assign bus.fu_start = go;
    assign bus.fu_inst  = go ? inst[sel] : '0;
    assign bus.fu_code  = go ? tag[sel]  : '0;
    assign bus.fu_reg1  = go ? vj[sel]   : '0;
    assign bus.fu_reg2  = go ? vk[sel]   : '0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i]  <= E_FREE;
                inst[i] <= '0;
                tag[i]  <= '0;
                qj[i]   <= '0;
                qk[i]   <= '0;
                vj[i]   <= '0;
                vk[i]   <= '0;
            end
            state            <= S_IDLE;
            cur              <= '0;
            bus.cdb_req      <= 1'b0;
            bus.cdb_tag_out  <= '0;
            bus.cdb_data_out <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (ent[i] == E_WAIT) begin
                    if (hit_j[i]) begin
                        vj[i] <= bus.cdb_data_in;
                        qj[i] <= '0;
                    end
                    if (hit_k[i]) begin
                        vk[i] <= bus.cdb_data_in;
                        qk[i] <= '0;
                    end
                    if ((qj[i] == '0 || hit_j[i]) && (qk[i] == '0 || hit_k[i])) ent[i] <= E_READY;
                end
            if (take) begin
                ent[slot]  <= ((bus.issue_qj == '0 || in_j) && (bus.issue_qk == '0 || in_k)) ? E_READY : E_WAIT;
                inst[slot] <= bus.issue_inst;
                tag[slot]  <= bus.issue_tag;
                vj[slot]   <= in_j ? bus.cdb_data_in : bus.issue_vj;
                vk[slot]   <= in_k ? bus.cdb_data_in : bus.issue_vk;
                qj[slot]   <= in_j ? '0 : bus.issue_qj;
                qk[slot]   <= in_k ? '0 : bus.issue_qk;
            end
            case (state)
                S_IDLE:
                    if (go) begin
                        ent[sel] <= E_EXEC;
                        cur      <= sel;
                        state    <= S_EXEC;
                    end
                S_EXEC:
                    if (bus.fu_done && bus.fu_code_out == tag[cur]) begin
                        bus.cdb_data_out <= bus.fu_dout;
                        bus.cdb_tag_out  <= bus.fu_code_out;
                        bus.cdb_req      <= 1'b1;
                        state            <= S_BCAST;
                    end
                S_BCAST:
                    if (bus.cdb_grant) begin
                        bus.cdb_req <= 1'b0;
                        ent[cur]    <= E_FREE;
                        state       <= S_IDLE;
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_fu_scheduler.sv
// tb_rs_fu_scheduler: table-driven and directed checks of the reservation-station scheduler
module tb_rs_fu_scheduler;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] occ;
    int         errors = 0;
    int         checks = 0;
    rs_fu_scheduler_if bus ();
    rs_fu_scheduler dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave), .occupancy(occ));
    always #5 clock = ~clock;
    typedef struct {
        int iv, itag, iqj, ivj, ivk;
        int avail, done, code, dout, grant;
        int cv, ctag, cdata;
        int rdy, start, ecode, er1, er2;
        int req, etag, edata, occ;
    } vec_t;
    vec_t v [12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic issue(input int t, input int q, input int a, input int b);
        bus.issue_valid = 1'b1;
        bus.issue_tag   = 3'(t);
        bus.issue_inst  = 16'h0100 | 16'(t);
        bus.issue_qj    = 3'(q);
        bus.issue_qk    = 3'd0;
        bus.issue_vj    = 16'(a);
        bus.issue_vk    = 16'(b);
        @(negedge clock);
        chk("issue_ready", 32'(bus.issue_ready), 1);
        tick();
        bus.issue_valid = 1'b0;
    endtask
    task automatic bcast(input int t, input int d);
        bus.cdb_valid_in = 1'b1;
        bus.cdb_tag_in   = 3'(t);
        bus.cdb_data_in  = 16'(d);
        tick();
        bus.cdb_valid_in = 1'b0;
    endtask
    // waits for a dispatch, acts as a one-cycle unit, then grants after hold cycles
    task automatic dispatch_one(input int t, input int r1, input int d, input int hold);
        int n = 0;
        @(negedge clock);
        while (!bus.fu_start && n < 20) begin
            tick();
            @(negedge clock);
            n++;
        end
        chk("dispatch_start", 32'(bus.fu_start), 1);
        chk("dispatch_code", 32'(bus.fu_code), 32'(t));
        chk("dispatch_inst", 32'(bus.fu_inst), 32'h0100 | 32'(t));
        chk("dispatch_reg1", 32'(bus.fu_reg1), 32'(r1));
        tick();
        bus.fu_avail    = 1'b0;
        bus.fu_done     = 1'b1;
        bus.fu_code_out = 3'(t);
        bus.fu_dout     = 16'(d);
        tick();
        bus.fu_done = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_req", 32'(bus.cdb_req), 1);
            chk("hold_tag", 32'(bus.cdb_tag_out), 32'(t));
            chk("hold_data", 32'(bus.cdb_data_out), 32'(d));
            chk("hold_no_start", 32'(bus.fu_start), 0);
            tick();
        end
        bus.cdb_grant = 1'b1;
        @(negedge clock);
        chk("bcast_req", 32'(bus.cdb_req), 1);
        chk("bcast_tag", 32'(bus.cdb_tag_out), 32'(t));
        chk("bcast_data", 32'(bus.cdb_data_out), 32'(d));
        tick();
        bus.cdb_grant = 1'b0;
        bus.fu_avail  = 1'b1;
    endtask
    initial begin
        //        iv tag qj vj vk  av dn cd dout gr  cv ct cdat  rdy st ec r1 r2  rq tg dat occ
        v[0]  = '{1, 1, 0, 5, 3,  1, 0, 0, 0,  0,  0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0,  0};
        v[1]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0,  0,  0, 0, 0,   1, 1, 1, 5, 3,   0, 0, 0,  1};
        v[2]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0,  1};
        v[3]  = '{0, 0, 0, 0, 0,  0, 1, 1, 8,  0,  0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0,  1};
        v[4]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  1,  0, 0, 0,   1, 0, 0, 0, 0,   1, 1, 8,  1};
        v[5]  = '{1, 2, 1, 0, 4,  1, 0, 0, 0,  0,  0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0,  0};
        v[6]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0,  0,  1, 1, 20,  1, 0, 0, 0, 0,   0, 0, 0,  1};
        v[7]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0,  0,  0, 0, 0,   1, 1, 2, 20, 4,  0, 0, 0,  1};
        v[8]  = '{0, 0, 0, 0, 0,  0, 1, 3, 99, 0,  0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0,  1};
        v[9]  = '{0, 0, 0, 0, 0,  0, 1, 2, 16, 0,  0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0,  1};
        v[10] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  1,  0, 0, 0,   1, 0, 0, 0, 0,   1, 2, 16, 1};
        v[11] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0,  0};
        bus.issue_valid = 0; bus.issue_inst = 0; bus.issue_tag = 0; bus.issue_qj = 0; bus.issue_qk = 0;
        bus.issue_vj = 0; bus.issue_vk = 0; bus.cdb_valid_in = 0; bus.cdb_tag_in = 0; bus.cdb_data_in = 0;
        bus.fu_avail = 0; bus.fu_done = 0; bus.fu_code_out = 0; bus.fu_dout = 0; bus.cdb_grant = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_ready", 32'(bus.issue_ready), 1);
        chk("reset_start", 32'(bus.fu_start), 0);
        chk("reset_req", 32'(bus.cdb_req), 0);
        chk("reset_occ", 32'(occ), 0);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.issue_valid  = v[k].iv[0];
            bus.issue_tag    = 3'(v[k].itag);
            bus.issue_inst   = 16'h0100 | 16'(v[k].itag);
            bus.issue_qj     = 3'(v[k].iqj);
            bus.issue_qk     = 3'd0;
            bus.issue_vj     = 16'(v[k].ivj);
            bus.issue_vk     = 16'(v[k].ivk);
            bus.fu_avail     = v[k].avail[0];
            bus.fu_done      = v[k].done[0];
            bus.fu_code_out  = 3'(v[k].code);
            bus.fu_dout      = 16'(v[k].dout);
            bus.cdb_grant    = v[k].grant[0];
            bus.cdb_valid_in = v[k].cv[0];
            bus.cdb_tag_in   = 3'(v[k].ctag);
            bus.cdb_data_in  = 16'(v[k].cdata);
            @(negedge clock);
            chk($sformatf("v%0d_ready", k), 32'(bus.issue_ready), 32'(v[k].rdy));
            chk($sformatf("v%0d_start", k), 32'(bus.fu_start), 32'(v[k].start));
            chk($sformatf("v%0d_code", k), 32'(bus.fu_code), 32'(v[k].ecode));
            chk($sformatf("v%0d_reg1", k), 32'(bus.fu_reg1), 32'(v[k].er1));
            chk($sformatf("v%0d_reg2", k), 32'(bus.fu_reg2), 32'(v[k].er2));
            chk($sformatf("v%0d_req", k), 32'(bus.cdb_req), 32'(v[k].req));
            if (v[k].req != 0) begin
                chk($sformatf("v%0d_tag", k), 32'(bus.cdb_tag_out), 32'(v[k].etag));
                chk($sformatf("v%0d_data", k), 32'(bus.cdb_data_out), 32'(v[k].edata));
            end
            chk($sformatf("v%0d_occ", k), 32'(occ), 32'(v[k].occ));
            tick();
        end
        bus.issue_valid = 0; bus.cdb_valid_in = 0; bus.fu_done = 0; bus.cdb_grant = 0; bus.fu_avail = 0;
        // full station: four waiters on tag 7, a fifth issue is refused
        for (int t = 1; t <= 4; t++) issue(t, 7, 0, t);
        bus.issue_valid = 1'b1;
        bus.issue_tag   = 3'd5;
        bus.issue_inst  = 16'h0105;
        bus.issue_qj    = 3'd0;
        @(negedge clock);
        chk("full_ready", 32'(bus.issue_ready), 0);
        chk("full_occ", 32'(occ), 4);
        tick();
        bus.issue_valid = 1'b0;
        @(negedge clock);
        chk("full_occ_after", 32'(occ), 4);
        tick();
        bcast(7, 50);
        bus.fu_avail = 1'b1;
        for (int t = 1; t <= 4; t++) dispatch_one(t, 50, 100 + t, t == 1 ? 5 : 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            chk("drained_occ", 32'(occ), 0);
            chk("drained_no_start", 32'(bus.fu_start), 0);
            tick();
        end
        // entry 2 allocated well before entry 0 is reused; both then wake together
        bus.fu_avail = 1'b0;
        issue(1, 0, 11, 0);
        issue(2, 5, 0, 0);
        issue(3, 6, 0, 0);
        bus.fu_avail = 1'b1;
        dispatch_one(1, 11, 21, 0);
        bus.fu_avail = 1'b0;
        issue(4, 6, 0, 0);
        bcast(6, 60);
        bus.fu_avail = 1'b1;
`ifdef AGE_PRIORITY_EN
        dispatch_one(3, 60, 33, 0);
        dispatch_one(4, 60, 44, 0);
`else
        dispatch_one(4, 60, 44, 0);
        dispatch_one(3, 60, 33, 0);
`endif
        bcast(5, 55);
        dispatch_one(2, 55, 22, 0);
        // reset while the unit is executing
        issue(5, 0, 1, 1);
        begin
            int n = 0;
            @(negedge clock);
            while (!bus.fu_start && n < 20) begin
                tick();
                @(negedge clock);
                n++;
            end
            chk("rst_pre_start", 32'(bus.fu_start), 1);
        end
        tick();
        bus.fu_avail = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_start", 32'(bus.fu_start), 0);
        chk("rst_req", 32'(bus.cdb_req), 0);
        chk("rst_tag", 32'(bus.cdb_tag_out), 0);
        chk("rst_data", 32'(bus.cdb_data_out), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_ready", 32'(bus.issue_ready), 1);
        tick();
        reset_n         = 1'b1;
        bus.fu_avail    = 1'b1;
        bus.fu_done     = 1'b1;
        bus.fu_code_out = 3'd5;
        bus.fu_dout     = 16'd77;
        tick();
        bus.fu_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            chk("post_rst_req", 32'(bus.cdb_req), 0);
            chk("post_rst_start", 32'(bus.fu_start), 0);
            chk("post_rst_occ", 32'(occ), 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rs_fu_scheduler.md
Name: rs_fu_scheduler

Overview:
- Reservation-station scheduler for a single Tomasulo functional unit; the functional unit executes add/sub/mul and ld/sd.
- Holds DEPTH pending instructions and captures missing operands by snooping the common data bus (CDB).
- Dispatches one ready entry at a time to the unit using its start/available/done handshake.
- Requests the CDB to broadcast each result with its tag, and frees the entry when the broadcast is granted.

Parameters:
- DEPTH, 4: number of reservation-station entries (2..8).
- DATA_W, 16: operand/result width.
- TAG_W, 3: producer tag width. Tag 0 is reserved and means "operand value valid, no dependency".

Ports:
- clock  in  1  single rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode offers an instruction.
- issue_ready  out  1  a free entry exists; an issue transfers when issue_valid & issue_ready.
- issue_inst  in  16  instruction; bits [3:0] are the opcode.
- issue_tag  in  TAG_W  destination tag of this instruction (nonzero).
- issue_vj, issue_vk  in  DATA_W  operand values.
- issue_qj, issue_qk  in  TAG_W  producer tags; 0 means the corresponding v is valid.
- cdb_valid_in  in  1  a CDB broadcast is present this cycle.
- cdb_tag_in  in  TAG_W  tag of the CDB broadcast.
- cdb_data_in  in  DATA_W  data of the CDB broadcast.
- fu_start  out  1  one-cycle dispatch pulse to the functional unit.
- fu_inst  out  16  instruction sent with the dispatch.
- fu_code  out  TAG_W  tag sent with the dispatch.
- fu_reg1, fu_reg2  out  DATA_W  operands vj and vk.
- fu_avail  in  1  functional unit is idle.
- fu_done  in  1  result is valid this cycle.
- fu_code_out  in  TAG_W  tag returned with the result.
- fu_dout  in  DATA_W  result value.
- cdb_req  out  1  request to broadcast on the CDB.
- cdb_grant  in  1  CDB arbiter grant.
- cdb_tag_out  out  TAG_W  tag being broadcast.
- cdb_data_out  out  DATA_W  result being broadcast.
- occupancy  out  $clog2(DEPTH+1)  number of non-free entries.

Behaviour:
- Reset (asynchronous on reset_n low, including mid-operation):
  - all entries FREE and the FSM goes to IDLE;
  - fu_start, cdb_req, fu_inst, fu_code, fu_reg1, fu_reg2, cdb_tag_out, cdb_data_out and occupancy all 0;
  - issue_ready=1;
  - any in-flight functional-unit result is ignored.
- Entry states: FREE, WAIT (some q nonzero), READY (qj=qk=0), EXEC (dispatched, awaiting broadcast).
- Allocation:
  - the lowest-index FREE entry takes the issue;
  - issue_ready = any FREE entry (combinational).
- Snoop:
  - every cycle with cdb_valid_in, each WAIT entry whose qj (or qk) equals cdb_tag_in latches cdb_data_in into vj (or vk) and clears that q;
  - an entry whose last dependency clears goes to READY at the same edge;
  - an issue whose issue_qj/qk matches the same-cycle CDB tag captures the data directly (no missed wakeup).
- Scheduler FSM:
  - IDLE: if any READY entry and fu_avail, select one and go to EXEC.
    - Selection is the lowest index unless AGE_PRIORITY_EN.
    - In that cycle, present the entry's instruction, tag and operands on fu_inst, fu_code, fu_reg1 and fu_reg2, and pulse fu_start for one cycle.
    - The selected entry goes to EXEC.
  - EXEC: wait for fu_done with fu_code_out equal to the dispatched tag.
    - On a match, latch fu_dout and the tag into cdb_data_out/cdb_tag_out, set cdb_req=1, and go to BCAST.
    - fu_done with a non-matching tag is ignored.
  - BCAST: hold cdb_req and the latched data stable until cdb_grant.
    - The edge that samples cdb_grant clears cdb_req, frees the entry and returns to IDLE.
- Latency:
  - issue with both operands valid at edge n means READY after edge n;
  - fu_start is asserted in cycle n+1 if fu_avail;
  - minimum issue-to-cdb_req time = 1 + unit latency + 1 cycles.
- Boundaries:
  - Full: issue_ready=0; issue_valid is ignored without loss.
  - Simultaneous free (grant) and issue: the freed slot is not reusable until the next cycle; occupancy is updated by net change.
  - Own broadcast: an own result also arrives via cdb_*_in and wakes dependents normally.
  - fu_avail low in IDLE: no dispatch; READY entries keep waiting.
  - Tag 0 never issues; issue_tag=0 is a protocol error and is not checked.

Optional Feature:
- Macro: AGE_PRIORITY_EN.
- When defined:
  - each entry stores a DEPTH-wide age counter, zeroed on allocation and incremented each cycle while not FREE (saturating);
  - IDLE selects the READY entry with the largest age, with ties going to the lowest index.
- When undefined: no age state; IDLE selects the lowest-index READY entry.

Test Plan:
- Issue ADD tag=1, vj=5, vk=3, q=0; fu_avail=1; the unit returns fu_done, code 1, dout 8 after 2 cycles; grant immediately -> fu_start in the cycle after issue; cdb_req with tag=1, data=8; entry freed; occupancy back to 0.
- Issue SUB tag=2 with qj=1, then CDB tag=1 data=20 -> entry latches vj=20, turns READY and dispatches with fu_reg1=20.
- Fill 4 entries with qj=7, issue a 5th -> issue_ready=0 and the 5th is not accepted; one CDB tag=7 broadcast wakes all 4, and they dispatch one at a time in index order.
- Hold cdb_grant low for 5 cycles in BCAST -> cdb_req, cdb_tag_out and cdb_data_out stay constant; no new fu_start.
- Drop reset_n while in EXEC -> all outputs 0 immediately, occupancy=0; a later fu_done is ignored.
- With AGE_PRIORITY_EN, make entry 2 older than entry 0 and have both READY -> entry 2 dispatches first; without the macro, entry 0 dispatches first.
